s_axil_regfile: RTL and testbench
=================================

# s_axil_regfile

- Parametrised AXI4-Lite slave register file.
- Provides NUM_REGS software-visible registers of DATA_WIDTH bits with byte-strobe writes.
- Registers can be individually marked read-only; read-only registers return hardware status inputs.
- Accepts AW and W independently, reports decode/permission errors, and exposes all registers and per-register write pulses to the surrounding logic as the control/status block of a peripheral.

## Interface
Parameters:
- ADDR_WIDTH, 8, AXI byte address width; must cover NUM_REGS*DATA_WIDTH/8 bytes.
- DATA_WIDTH, 32, register and bus width; 32 or 64 only.
- NUM_REGS, 16, number of registers, 1..2^(ADDR_WIDTH-log2(DATA_WIDTH/8)).
- RO_MASK, {NUM_REGS{1'b0}}, bit i=1 makes register i read-only (value taken from reg_in).

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  asynchronous active-low reset.
- AWADDR  in  ADDR_WIDTH  write address; AWVALID in 1; AWREADY out 1.
- WDATA  in  DATA_WIDTH; WSTRB in DATA_WIDTH/8; WVALID in 1; WREADY out 1.
- BRESP  out  2; BVALID out 1; BREADY in 1.
- ARADDR  in  ADDR_WIDTH; ARVALID in 1; ARREADY out 1.
- RDATA  out  DATA_WIDTH; RRESP out 2; RVALID out 1; RREADY in 1.
- reg_out  out  NUM_REGS*DATA_WIDTH  flat current register values, register i at [i*DATA_WIDTH +: DATA_WIDTH].
- reg_in  in  NUM_REGS*DATA_WIDTH  status values for read-only registers; bits of writable registers ignored.
- wr_pulse  out  NUM_REGS  one-cycle pulse for register i on the cycle its new value first appears.

## Operation
Register index:
- index = addr[ADDR_WIDTH-1 : log2(DATA_WIDTH/8)].
- Low byte-offset bits are ignored.
- Out of range: index >= NUM_REGS.

Write path:
- AW holding slot: AWREADY = !aw_full. On handshake, store AWADDR and set aw_full.
- W holding slot: WREADY = !w_full. On handshake, store WDATA and WSTRB and set w_full.
- Either channel may arrive first, by any number of cycles.
- Commit condition: aw_full & w_full & (!BVALID | BREADY).
- At the commit edge:
  - Update the register byte-by-byte where WSTRB=1; bytes with WSTRB=0 keep their value.
  - Clear both slots.
  - Set BVALID and load BRESP.
  - Pulse wr_pulse[index] for one cycle.
- No update and no wr_pulse when index is out of range or RO_MASK[index]=1.
- BVALID holds, with BRESP stable, until BREADY is sampled high.

Read path:
- ARREADY = !RVALID | RREADY (back-to-back reads allowed).
- On AR handshake, RDATA is loaded from the current value of register index:
  - reg_in slice if read-only;
  - stored register if writable;
  - 0 if out of range.
- RRESP is loaded at the same time; RVALID is set.
- RVALID clears on RREADY unless a new AR handshake occurs in the same cycle.
- RDATA and RRESP stay stable while RVALID=1 and RREADY=0.

Responses:
- OKAY=2'b00, SLVERR=2'b10 (see Configuration).

## Timing
Reset (ARESETN low, asynchronous):
- Values forced:
  - BVALID=0, RVALID=0.
  - BRESP=0, RRESP=0, RDATA=0.
  - reg_out=0, wr_pulse=0.
  - aw_full=0, w_full=0.
- AWREADY=WREADY=ARREADY=1 while in reset and after release.
- Reset mid-transaction discards held AW/W and any pending B/R without a response.

Write timing:
- AW and W handshake in cycle N → commit edge end of N+1 (if B is free).
- At that edge: reg_out, wr_pulse and BVALID become valid in cycle N+2.
- Slots free in N+2, so sustained throughput is 1 write per 2 cycles.
- B backpressure (BVALID=1, BREADY=0) stalls the commit. Both slots stay full, so AWREADY/WREADY stay low.

Read timing:
- AR handshake in cycle N → RVALID in N+1.
- With RREADY held high, 1 read per cycle.

Simultaneous events:
- A read handshaking on the same edge as a commit to the same register returns the pre-write value.
- A read of a read-only register returns reg_in as sampled at the AR handshake edge.
- WSTRB=0 commits with an OKAY response and no change, but still pulses wr_pulse.

## Configuration
- S_AXIL_REGFILE_SLVERR_EN defined:
  - An out-of-range write or a write to a read-only register responds with BRESP=SLVERR.
  - An out-of-range read responds with RRESP=SLVERR and RDATA=0.
- Not defined:
  - All responses are OKAY.
  - Illegal writes are silently dropped; out-of-range reads return 0.
- Write suppression and the wr_pulse rules are identical in both builds.

## Test plan
- Reset, then write 0xDEADBEEF to 0x08 with WSTRB=4'hF, AW and W in the same cycle:
  - BVALID in the 2nd cycle after the handshake with BRESP=00.
  - reg_out reg2=0xDEADBEEF; wr_pulse[2] high for 1 cycle.
  - A read of 0x08 returns 0xDEADBEEF.
- Partial write: WSTRB=4'b0101, data 0x11223344 to reg2 (holding 0xDEADBEEF) → reg2=0xDE22BE44.
- W presented 5 cycles before AW, BREADY low for 3 cycles:
  - Exactly one commit.
  - BVALID and BRESP held stable.
  - AWREADY/WREADY low until B completes.
- RO_MASK bit 1 set, reg_in reg1=0xCAFE0001:
  - Writing reg1 leaves it unchanged, no wr_pulse; BRESP=10 with the macro, 00 without.
  - Reading reg1 returns 0xCAFE0001.
- NUM_REGS=12: read 0x30 → RDATA=0 with RRESP=10 (macro defined) / 00 (undefined); write 0x30 changes nothing.
- Reads of regs 0..3 back-to-back with RREADY=1 → 4 RVALID cycles, in order. Assert ARESETN low mid-burst → RVALID, BVALID and reg_out drop to 0 immediately.

Source files
------------

// File: rtl/s_axil_regfile.sv
// rtl/s_axil_regfile.sv - AXI4-Lite slave register file with byte-strobe writes and read-only status registers.
// Optional S_AXIL_REGFILE_SLVERR_EN: answer illegal accesses with SLVERR instead of OKAY.
module s_axil_regfile #(
  parameter int                  ADDR_WIDTH = 8,
  parameter int                  DATA_WIDTH = 32,
  parameter int                  NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] reg_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - OFFS;
  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef S_AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] RESP_ERR = 2'b10;
`else
  localparam logic [1:0] RESP_ERR = 2'b00;
`endif

  logic                  aw_full;
  logic                  w_full;
  logic [IDX_W-1:0]      aw_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  commit;
  logic                  ar_hs;
  logic [IDX_W-1:0]      ar_idx;
  logic                  w_legal;
  logic                  r_hit;
  logic [DATA_WIDTH-1:0] r_value;
  logic [NUM_REGS-1:0]   wr_sel;
  logic                  unused;

  assign AWREADY = !aw_full;
  assign WREADY  = !w_full;
  assign ARREADY = !RVALID || RREADY;
  assign commit  = aw_full && w_full && (!BVALID || BREADY);
  assign ar_hs   = ARVALID && ARREADY;
  assign ar_idx  = ARADDR[ADDR_WIDTH-1:OFFS];
  assign unused  = &{1'b0, AWADDR[OFFS-1:0], ARADDR[OFFS-1:0]};

  // Decoding by equality against each register index keeps out-of-range
  // addresses from ever selecting anything, so no separate bound check is needed.
  always_comb begin
    w_legal = 1'b0;
    r_hit   = 1'b0;
    r_value = '0;
    wr_sel  = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (aw_idx == IDX_W'(i) && !RO_MASK[i]) begin
        w_legal   = 1'b1;
        wr_sel[i] = commit;
      end
      if (ar_idx == IDX_W'(i)) begin
        r_hit   = 1'b1;
        r_value = RO_MASK[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : regs[i];
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_idx  <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end
      if (AWVALID && AWREADY) begin
        aw_full <= 1'b1;
        aw_idx  <= AWADDR[ADDR_WIDTH-1:OFFS];
      end
      if (WVALID && WREADY) begin
        w_full <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= wr_sel;
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int b = 0; b < STRB_W; b++) begin
          if (wr_sel[i] && w_strb[b]) regs[i][b*8 +: 8] <= w_data[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      BVALID <= 1'b0;
      BRESP  <= RESP_OKAY;
      RVALID <= 1'b0;
      RRESP  <= RESP_OKAY;
      RDATA  <= '0;
    end else begin
      if (commit) begin
        BVALID <= 1'b1;
        BRESP  <= w_legal ? RESP_OKAY : RESP_ERR;
      end else if (BREADY) begin
        BVALID <= 1'b0;
      end
      if (ar_hs) begin
        RVALID <= 1'b1;
        RDATA  <= r_value;
        RRESP  <= r_hit ? RESP_OKAY : RESP_ERR;
      end else if (RREADY) begin
        RVALID <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
    assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

endmodule

// File: tb/tb_s_axil_regfile.sv
// tb/tb_s_axil_regfile.sv - self-checking bench for s_axil_regfile (12 registers, register 1 read-only).
module tb_s_axil_regfile;

  localparam int NR = 12;
  localparam logic [NR-1:0] RO = 12'h002;
`ifdef S_AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic            ACLK = 1'b0;
  logic            ARESETN;
  logic [7:0]      AWADDR;
  logic            AWVALID;
  logic            AWREADY;
  logic [31:0]     WDATA;
  logic [3:0]      WSTRB;
  logic            WVALID;
  logic            WREADY;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY;
  logic [7:0]      ARADDR;
  logic            ARVALID;
  logic            ARREADY;
  logic [31:0]     RDATA;
  logic [1:0]      RRESP;
  logic            RVALID;
  logic            RREADY;
  logic [NR*32-1:0] reg_out;
  logic [NR*32-1:0] reg_in;
  logic [NR-1:0]   wr_pulse;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model [NR];

  s_axil_regfile #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .NUM_REGS(NR), .RO_MASK(RO)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  function automatic logic [31:0] exp_rdata(input logic [7:0] a);
    int idx = int'(a[7:2]);
    if (idx >= NR) return 32'h0;
    if (RO[idx]) return reg_in[idx*32 +: 32];
    return model[idx];
  endfunction

  function automatic logic [1:0] exp_rresp(input logic [7:0] a);
    return (int'(a[7:2]) >= NR) ? ERR : 2'b00;
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < NR; i++) check(tag, 64'(reg_out[i*32 +: 32]), 64'(model[i]));
  endtask

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    int idx = int'(addr[7:2]);
    bit legal = (idx < NR) && !RO[idx];
    bit aw_done = 0;
    bit w_done = 0;
    bit aw_hs, w_hs;
    int cyc = 0;
    logic [NR-1:0] exp_pulse = legal ? (NR'(1) << idx) : '0;
    logic [1:0] exp_resp = legal ? 2'b00 : ERR;
    BREADY = 1'b0;
    AWADDR = addr; WDATA = data; WSTRB = strb;
    while (!(aw_done && w_done) && cyc < 40) begin
      AWVALID = !aw_done && (cyc >= aw_dly);
      WVALID  = !w_done && (cyc >= w_dly);
      aw_hs = AWVALID && AWREADY;
      w_hs  = WVALID && WREADY;
      tick();
      if (aw_hs) aw_done = 1;
      if (w_hs) w_done = 1;
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      cyc++;
    end
    check("wr_handshake", 64'(aw_done && w_done), 64'd1);
    check("b_early", 64'(BVALID), 64'd0);
    check("pulse_early", 64'(wr_pulse), 64'd0);
    tick();
    if (legal)
      for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
    check("bvalid", 64'(BVALID), 64'd1);
    check("bresp", 64'(BRESP), 64'(exp_resp));
    check("wr_pulse", 64'(wr_pulse), 64'(exp_pulse));
    check_regs("reg_out");
    for (int k = 0; k < b_dly; k++) begin
      tick();
      check("b_hold", 64'(BVALID), 64'd1);
      check("bresp_hold", 64'(BRESP), 64'(exp_resp));
      check("pulse_once", 64'(wr_pulse), 64'd0);
    end
    BREADY = 1'b1;
    tick();
    check("b_clear", 64'(BVALID), 64'd0);
    check("pulse_clear", 64'(wr_pulse), 64'd0);
    BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] addr, input int r_dly);
    logic [31:0] ed = exp_rdata(addr);
    logic [1:0]  er = exp_rresp(addr);
    RREADY = 1'b0;
    ARADDR = addr;
    ARVALID = 1'b1;
    check("arready", 64'(ARREADY), 64'd1);
    tick();
    ARVALID = 1'b0;
    check("rvalid", 64'(RVALID), 64'd1);
    check("rdata", 64'(RDATA), 64'(ed));
    check("rresp", 64'(RRESP), 64'(er));
    for (int k = 0; k < r_dly; k++) begin
      tick();
      check("r_hold", 64'(RVALID), 64'd1);
      check("rdata_hold", 64'(RDATA), 64'(ed));
    end
    RREADY = 1'b1;
    tick();
    check("r_clear", 64'(RVALID), 64'd0);
    RREADY = 1'b0;
  endtask

  initial begin
    ARESETN = 1'b0;
    AWADDR = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 0;
    ARADDR = '0; ARVALID = 0; RREADY = 0; reg_in = '0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    #23;
    check("rst_bvalid", 64'(BVALID), 64'd0);
    check("rst_rvalid", 64'(RVALID), 64'd0);
    check("rst_ready", 64'({AWREADY, WREADY, ARREADY}), 64'h7);
    check("rst_regout", 64'(|reg_out), 64'd0);
    check("rst_pulse", 64'(wr_pulse), 64'd0);
    ARESETN = 1'b1;
    tick();

    do_write(8'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(8'h08, 0);
    do_write(8'h08, 32'h11223344, 4'b0101, 0, 0, 1);
    check("partial_const", 64'(reg_out[2*32 +: 32]), 64'hDE22BE44);
    do_write(8'h14, 32'h12345678, 4'h0, 1, 0, 0);

    // Second write waits behind an unacknowledged response, W arriving 5 cycles before AW.
    AWADDR = 8'h0C; WDATA = 32'h0A0A0A0A; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    tick();
    AWVALID = 0; WVALID = 0;
    model[3] = 32'h0A0A0A0A;
    tick();
    check("stall_b_first", 64'(BVALID), 64'd1);
    WDATA = 32'h55667788; WVALID = 1;
    tick();
    WVALID = 0;
    repeat (4) tick();
    AWADDR = 8'h10; AWVALID = 1;
    tick();
    AWVALID = 0;
    for (int k = 0; k < 3; k++) begin
      check("stall_ready", 64'({AWREADY, WREADY}), 64'd0);
      check("stall_b", 64'({BVALID, BRESP}), 64'h4);
      check("stall_reg4", 64'(reg_out[4*32 +: 32]), 64'(model[4]));
      check("stall_pulse", 64'(wr_pulse), 64'd0);
      tick();
    end
    BREADY = 1;
    tick();
    model[4] = 32'h55667788;
    check("stall_commit_b", 64'(BVALID), 64'd1);
    check("stall_commit_pulse", 64'(wr_pulse), 64'h010);
    check_regs("stall_regs");
    tick();
    check("stall_done", 64'({BVALID, wr_pulse}), 64'd0);
    BREADY = 0;

    reg_in[1*32 +: 32] = 32'hCAFE0001;
    do_write(8'h04, 32'h99999999, 4'hF, 0, 2, 0);
    do_read(8'h04, 1);
    do_read(8'h30, 0);
    do_write(8'h30, 32'hFFFFFFFF, 4'hF, 0, 0, 0);

    for (int it = 0; it < 80; it++) begin
      logic [7:0] a;
      a = 8'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
      for (int i = 0; i < NR; i++) reg_in[i*32 +: 32] = $urandom;
      if ($urandom_range(0, 1) == 0)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2));
      else
        do_read(a, $urandom_range(0, 2));
    end

    // Leave a response pending, then stream reads of 0..3 and reset mid-burst.
    AWADDR = 8'h0C; WDATA = 32'h600DF00D; WSTRB = 4'hF; AWVALID = 1; WVALID = 1;
    tick();
    AWVALID = 0; WVALID = 0;
    model[3] = 32'h600DF00D;
    tick();
    check("burst_b_pending", 64'(BVALID), 64'd1);
    ARVALID = 1; RREADY = 1;
    for (int k = 0; k < 4; k++) begin
      ARADDR = 8'(k * 4);
      tick();
      check("burst_rvalid", 64'(RVALID), 64'd1);
      check("burst_rdata", 64'(RDATA), 64'(exp_rdata(8'(k * 4))));
    end
    ARADDR = 8'h00;
    #3;
    ARESETN = 1'b0;
    #1;
    check("async_rvalid", 64'(RVALID), 64'd0);
    check("async_bvalid", 64'(BVALID), 64'd0);
    check("async_regout", 64'(|reg_out), 64'd0);
    ARVALID = 0; RREADY = 0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    tick();
    ARESETN = 1'b1;
    tick();
    check("post_rst_ready", 64'({AWREADY, WREADY, ARREADY}), 64'h7);
    do_write(8'h00, 32'hA5A5A5A5, 4'hF, 0, 0, 0);
    do_read(8'h00, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
